// File: rtl/mmul2_pkg.sv
// Shared types and sizing helpers for the mmul2 operand loader.
package mmul2_pkg;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    RUN,
    DONE
  } mmul2_load_state_t;

  localparam int unsigned RA_DEFAULT = 2;
  localparam int unsigned CA_DEFAULT = 2;
  localparam int unsigned RB_DEFAULT = 2;
  localparam int unsigned CB_DEFAULT = 2;

  // Slot index width: enough for the larger matrix, never below one bit.
  function automatic int unsigned idx_width(input int unsigned na, input int unsigned nb);
    int unsigned m;
    m = (na > nb) ? na : nb;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

  localparam int unsigned NA = RA_DEFAULT * CA_DEFAULT;
  localparam int unsigned NB = RB_DEFAULT * CB_DEFAULT;
  localparam int unsigned IW = idx_width(NA, NB);

endpackage

// File: rtl/mmul2_loader_if.sv
// Element stream into the loader: valid/ready handshake with frame marker.
interface mmul2_loader_if #(
  parameter int unsigned W = 32
) ();

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/mmul2_loader_counter.sv
// Per-phase slot counter; terminal flags the last slot of the active phase.
module mmul2_load_counter #(
  parameter int unsigned IW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          inc,
  input  logic [IW-1:0] limit,
  output logic [IW-1:0] count,
  output logic          terminal
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == limit);

endmodule

// File: rtl/mmul2_loader.sv
// Packs a streamed A/B operand frame into flat buses and runs one mmul2 pass.
module mmul2_loader
  import mmul2_pkg::*;
#(
  parameter int unsigned RA = RA_DEFAULT,
  parameter int unsigned CA = CA_DEFAULT,
  parameter int unsigned RB = RB_DEFAULT,
  parameter int unsigned CB = CB_DEFAULT,
  parameter int unsigned W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  mmul2_loader_if.slave      in_bus,
  output logic [RA*CA*W-1:0] A,
  output logic [RB*CB*W-1:0] B,
  output logic               mmul_enable,
  input  logic               mmul_completed,
  output logic               done,
  output logic               dim_err,
  output logic               frame_err
);

  localparam int unsigned SLOTS_A = RA * CA;
  localparam int unsigned SLOTS_B = RB * CB;
  localparam int unsigned IDX_W   = idx_width(SLOTS_A, SLOTS_B);

  mmul2_load_state_t state, state_next;

  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] limit;
  logic             terminal;
  logic             xfer;
  logic             final_b;
  logic             bad_frame;
  logic             cnt_clear;
  logic             wr_a;
  logic             wr_b;

  assign dim_err = (CA != RB);

  assign xfer      = in_bus.in_valid && in_bus.in_ready;
  assign limit     = (state == LOAD_B) ? IDX_W'(SLOTS_B - 1) : IDX_W'(SLOTS_A - 1);
  assign final_b   = (state == LOAD_B) && terminal;
  // in_last must be set exactly on the closing B element, nowhere else.
  assign bad_frame = xfer && (in_bus.in_last != final_b);
  assign cnt_clear = (xfer && (terminal || bad_frame)) || (state == DONE);
  assign wr_a      = xfer && (state == LOAD_A);
  assign wr_b      = xfer && (state == LOAD_B);

  mmul2_load_counter #(
    .IW (IDX_W)
  ) u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (cnt_clear),
    .inc      (xfer),
    .limit    (limit),
    .count    (idx),
    .terminal (terminal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD_A;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD_A: begin
        if (bad_frame) begin
          state_next = LOAD_A;
        end else if (xfer && terminal) begin
          state_next = LOAD_B;
        end
      end
      LOAD_B: begin
        if (bad_frame) begin
          state_next = LOAD_A;
        end else if (xfer && terminal) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (mmul_completed) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = LOAD_A;
      default: state_next = LOAD_A;
    endcase
  end

  // Decoded from the async-reset state so enable drops the moment reset asserts.
  always_comb begin
    in_bus.in_ready = ((state == LOAD_A) || (state == LOAD_B)) && !dim_err;
    mmul_enable     = (state == RUN);
    done            = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
    end else if (bad_frame) begin
      frame_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A <= '0;
      B <= '0;
    end else begin
      for (int unsigned i = 0; i < SLOTS_A; i++) begin
        if (wr_a && (idx == IDX_W'(i))) begin
          A[i*W +: W] <= in_bus.in_data;
        end
      end
      for (int unsigned i = 0; i < SLOTS_B; i++) begin
        if (wr_b && (idx == IDX_W'(i))) begin
          B[i*W +: W] <= in_bus.in_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mmul2_loader.sv
// Randomized frame-level check of mmul2_loader against an element-order model.
module tb_mmul2_loader;

  localparam int NA = 4;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic completed = 1'b0;

  always #5 clk = ~clk;

  mmul2_loader_if #(.W(8)) bus ();
  mmul2_loader_if #(.W(8)) bus2 ();

  logic [31:0] a_bus, b_bus;
  logic        en, done, dim_err, ferr;
  logic [47:0] a2;
  logic [31:0] b2;
  logic        en2, done2, dim2, ferr2;

  mmul2_loader #(.RA(2), .CA(2), .RB(2), .CB(2), .W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_bus         (bus),
    .A              (a_bus),
    .B              (b_bus),
    .mmul_enable    (en),
    .mmul_completed (completed),
    .done           (done),
    .dim_err        (dim_err),
    .frame_err      (ferr)
  );

  mmul2_loader #(.RA(2), .CA(3), .RB(2), .CB(2), .W(8)) dut_dim (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_bus         (bus2),
    .A              (a2),
    .B              (b2),
    .mmul_enable    (en2),
    .mmul_completed (completed),
    .done           (done2),
    .dim_err        (dim2),
    .frame_err      (ferr2)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_a [4];
  logic [7:0] exp_b [4];
  logic [7:0] frame_data [8];
  int         pos = 0;
  bit         exp_ferr = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic [7:0] v [4]);
    logic [31:0] p;
    for (int i = 0; i < 4; i++) p[8*i +: 8] = v[i];
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      exp_a[i] = '0;
      exp_b[i] = '0;
    end
    pos = 0;
    exp_ferr = 1'b0;
  endtask

  // One element: idle gap, present it, wait (bounded) for acceptance, update model.
  task automatic send(input logic [7:0] d, input bit l, input int gap, output bit run);
    int waits;
    bit fin;
    waits = 0;
    run = 1'b0;
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (bus.in_ready !== 1'b1 && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 50) begin
      chk("ready_timeout", 64'd0, 64'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    fin = (pos == NA + NB - 1);
    if (pos < NA) exp_a[pos] = d;
    else exp_b[pos - NA] = d;
    if (l != fin) begin
      exp_ferr = 1'b1;
      pos = 0;
    end else if (fin) begin
      pos = 0;
      run = 1'b1;
    end else begin
      pos++;
    end
    chk("frame_err", ferr, exp_ferr);
    chk("enable_after_xfer", en, run);
  endtask

  // err_at: -1 clean, 0..6 early in_last on that element, 7 missing in_last.
  task automatic send_frame(input int err_at, input int gap, input int stray_at, output bit run);
    bit l;
    int g;
    run = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == stray_at) begin
        completed = 1'b1;
        repeat (2) begin
          @(negedge clk);
          chk("stray_no_done", done, 1'b0);
          chk("stray_no_enable", en, 1'b0);
          chk("stray_ready", bus.in_ready, 1'b1);
        end
        completed = 1'b0;
      end
      if (err_at < 0) l = (i == 7);
      else if (err_at == 7) l = 1'b0;
      else l = (i == err_at);
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      send(frame_data[i], l, g, run);
      if (err_at >= 0 && i == err_at) break;
    end
  endtask

  task automatic finish_run(input int delay);
    chk("A_packed", a_bus, pack(exp_a));
    chk("B_packed", b_bus, pack(exp_b));
    chk("ready_in_run", bus.in_ready, 1'b0);
    chk("enable_in_run", en, 1'b1);
    repeat (delay) begin
      @(negedge clk);
      chk("enable_hold", en, 1'b1);
      chk("no_early_done", done, 1'b0);
    end
    completed = 1'b1;
    @(negedge clk);
    completed = 1'b0;
    chk("done_pulse", done, 1'b1);
    chk("enable_fall", en, 1'b0);
    chk("ready_in_done", bus.in_ready, 1'b0);
    chk("A_stable", a_bus, pack(exp_a));
    chk("B_stable", b_bus, pack(exp_b));
    @(negedge clk);
    chk("done_single", done, 1'b0);
    chk("ready_rearm", bus.in_ready, 1'b1);
  endtask

  task automatic seq_data();
    for (int i = 0; i < 8; i++) frame_data[i] = 8'(i + 1);
  endtask

  initial begin
    bit run;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.in_last = 1'b0;
    model_reset();

    repeat (2) @(negedge clk);
    chk("rst_enable", en, 1'b0);
    chk("rst_A", a_bus, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", bus.in_ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_frame_err", ferr, 1'b0);
    chk("rst_B", b_bus, 32'h0);
    chk("dim_ok", dim_err, 1'b0);

    // Dimension mismatch instance never accepts.
    bus2.in_valid = 1'b1;
    bus2.in_data  = 8'h5A;
    repeat (20) begin
      @(negedge clk);
      chk("dim_err", dim2, 1'b1);
      chk("dim_ready", bus2.in_ready, 1'b0);
      chk("dim_enable", en2, 1'b0);
    end
    bus2.in_valid = 1'b0;

    // Basic load.
    seq_data();
    send_frame(-1, 0, -1, run);
    chk("basic_A_const", a_bus, 32'h04030201);
    chk("basic_B_const", b_bus, 32'h08070605);
    finish_run(3);

    // Backpressure with valid pattern 1,0,0,1,...
    send_frame(-1, 2, -1, run);
    chk("bp_A_const", a_bus, 32'h04030201);
    chk("bp_B_const", b_bus, 32'h08070605);
    finish_run(1);

    // Framing error on element 6, then a clean frame.
    send_frame(5, 0, -1, run);
    chk("ferr_set", ferr, 1'b1);
    chk("ferr_no_enable", en, 1'b0);
    chk("ferr_ready", bus.in_ready, 1'b1);
    send_frame(-1, 0, -1, run);
    chk("ferr_A_const", a_bus, 32'h04030201);
    chk("ferr_B_const", b_bus, 32'h08070605);
    finish_run(2);

    // Stray completion while idle and mid-frame.
    completed = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_stray_done", done, 1'b0);
      chk("idle_stray_ready", bus.in_ready, 1'b1);
    end
    completed = 1'b0;
    for (int i = 0; i < 8; i++) frame_data[i] = 8'($urandom);
    send_frame(-1, 0, 5, run);
    finish_run(0);

    // Randomized frames, some with framing faults.
    for (int f = 0; f < 12; f++) begin
      int e;
      for (int i = 0; i < 8; i++) frame_data[i] = 8'($urandom);
      e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      send_frame(e, -1, -1, run);
      if (run) finish_run(int'($urandom_range(0, 4)));
      else chk("rand_no_run", en, 1'b0);
    end

    // Reset asserted mid-RUN.
    for (int i = 0; i < 8; i++) frame_data[i] = 8'($urandom);
    send_frame(-1, 0, -1, run);
    chk("pre_reset_enable", en, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("reset_enable_drop", en, 1'b0);
    chk("reset_A", a_bus, pack(exp_a));
    chk("reset_B", b_bus, pack(exp_b));
    chk("reset_frame_err", ferr, 1'b0);
    chk("reset_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", bus.in_ready, 1'b1);
    seq_data();
    send_frame(-1, 0, -1, run);
    finish_run(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule
